// File: rtl/bp_fpga_host_nbf_tx_arb_if.sv
// Bundles the NBF packet inputs and the byte-stream output of the host
// transmit arbiter. The slave modport is the arbiter's view; the master
// modport is the view of whatever feeds packets and drains bytes.
interface bp_fpga_host_nbf_tx_arb_if #(
   parameter int num_src_p        = 2,
   parameter int nbf_addr_width_p = 40,
   parameter int nbf_data_width_p = 64
) ();
   localparam int nbf_width_lp   = 8 + nbf_addr_width_p + nbf_data_width_p;
   localparam int grant_width_lp = (num_src_p > 1) ? $clog2(num_src_p) : 1;

   logic [num_src_p*nbf_width_lp-1:0] nbf_i;
   logic [num_src_p-1:0]              nbf_v_i;
   logic [num_src_p-1:0]              nbf_ready_and_o;
   logic [7:0]                        byte_o;
   logic                              byte_v_o;
   logic                              byte_ready_and_i;
   logic                              busy_o;
   logic [grant_width_lp-1:0]         grant_src_o;

   modport master (
      output nbf_i, nbf_v_i, byte_ready_and_i,
      input  nbf_ready_and_o, byte_o, byte_v_o, busy_o, grant_src_o
   );

   modport slave (
      input  nbf_i, nbf_v_i, byte_ready_and_i,
      output nbf_ready_and_o, byte_o, byte_v_o, busy_o, grant_src_o
   );
endinterface

// File: rtl/bp_fpga_host_nbf_tx_arb.sv
// Multi-source NBF transmit arbiter and byte serializer for the host link.
// Each source has its own small FIFO; one source has strict priority and the
// rest are served round-robin. The granted packet is shifted out LSB byte
// first (opcode, addr LSB..MSB, data LSB..MSB).
// Optional feature macro: BP_FPGA_HOST_NBF_TX_CHECKSUM_EN appends one XOR
// checksum byte after every packet.
module bp_fpga_host_nbf_tx_arb #(
   parameter int num_src_p        = 2,
   parameter int nbf_addr_width_p = 40,
   parameter int nbf_data_width_p = 64,
   parameter int fifo_els_p       = 4,
   parameter int prio_src_p       = 0
) (
   input  logic clk_i,
   input  logic reset_i,
   bp_fpga_host_nbf_tx_arb_if.slave io
);
   localparam int nbf_width_lp   = 8 + nbf_addr_width_p + nbf_data_width_p;
   localparam int nbf_bytes_lp   = nbf_width_lp / 8;
   localparam int grant_width_lp = (num_src_p > 1) ? $clog2(num_src_p) : 1;
   localparam int ptr_width_lp   = $clog2(fifo_els_p);
   localparam int cnt_width_lp   = $clog2(fifo_els_p + 1);
   localparam int idx_width_lp   = $clog2(nbf_bytes_lp + 1);

`ifdef BP_FPGA_HOST_NBF_TX_CHECKSUM_EN
   typedef enum logic [1:0] {e_idle, e_send, e_csum} state_e;
`else
   typedef enum logic [0:0] {e_idle, e_send} state_e;
`endif

   state_e                     r_state;
   state_e                     w_state_next;

   logic [num_src_p-1:0]       w_fifo_empty;
   logic [num_src_p-1:0]       w_fifo_full;
   logic [num_src_p-1:0]       w_enq;
   logic [num_src_p-1:0]       w_deq;
   logic [nbf_width_lp-1:0]    w_fifo_head [num_src_p];

   logic                       w_pick_v;
   logic [grant_width_lp-1:0]  w_pick_src;
   int                         w_scan;
   logic                       w_load;
   logic                       w_send_hs;
   logic                       w_last_byte;

   logic [nbf_width_lp-1:0]    r_shift;
   logic [idx_width_lp-1:0]    r_byte_idx;
   logic [grant_width_lp-1:0]  r_grant;
   logic [grant_width_lp-1:0]  r_rr_ptr;
`ifdef BP_FPGA_HOST_NBF_TX_CHECKSUM_EN
   logic [7:0]                 r_csum;
`endif

   genvar gi;

   // Per-source FIFOs: storage is a plain array whose head is captured by the
   // serializer shift register on grant.
   generate
      for (gi = 0; gi < num_src_p; gi++) begin : g_fifo
         logic [nbf_width_lp-1:0] r_mem [fifo_els_p];
         logic [ptr_width_lp-1:0] r_wr_ptr;
         logic [ptr_width_lp-1:0] r_rd_ptr;
         logic [cnt_width_lp-1:0] r_count;

         assign w_fifo_empty[gi]   = (r_count == '0);
         assign w_fifo_full[gi]    = (r_count == cnt_width_lp'(fifo_els_p));
         assign w_enq[gi]          = io.nbf_v_i[gi] & io.nbf_ready_and_o[gi];
         assign w_deq[gi]          = w_load & (w_pick_src == grant_width_lp'(gi));
         assign w_fifo_head[gi]    = r_mem[r_rd_ptr];

         // Write port of the packet storage
         always_ff @(posedge clk_i) begin
            if (w_enq[gi]) begin
               r_mem[r_wr_ptr] <= io.nbf_i[gi*nbf_width_lp +: nbf_width_lp];
            end
         end

         // Pointer and occupancy bookkeeping
         always_ff @(posedge clk_i) begin
            if (reset_i) begin
               r_wr_ptr <= '0;
               r_rd_ptr <= '0;
               r_count  <= '0;
            end else begin
               if (w_enq[gi]) begin
                  r_wr_ptr <= (r_wr_ptr == ptr_width_lp'(fifo_els_p - 1)) ? '0
                              : r_wr_ptr + ptr_width_lp'(1);
               end
               if (w_deq[gi]) begin
                  r_rd_ptr <= (r_rd_ptr == ptr_width_lp'(fifo_els_p - 1)) ? '0
                              : r_rd_ptr + ptr_width_lp'(1);
               end
               if (w_enq[gi] && !w_deq[gi]) begin
                  r_count <= r_count + cnt_width_lp'(1);
               end else if (!w_enq[gi] && w_deq[gi]) begin
                  r_count <= r_count - cnt_width_lp'(1);
               end
            end
         end
      end
   endgenerate

   assign io.nbf_ready_and_o = ~w_fifo_full & {num_src_p{~reset_i}};
   assign io.busy_o          = ~reset_i & ((r_state != e_idle) | ~(&w_fifo_empty));

   assign w_send_hs   = (r_state == e_send) & io.byte_ready_and_i;
   assign w_last_byte = (r_byte_idx == idx_width_lp'(nbf_bytes_lp - 1));

   // Choose the next source: priority source first, else first non-empty
   // source at or after the round-robin pointer (priority source skipped)
   always_comb begin
      w_pick_v   = 1'b0;
      w_pick_src = '0;
      w_scan     = 0;
      if (!w_fifo_empty[prio_src_p]) begin
         w_pick_v   = 1'b1;
         w_pick_src = grant_width_lp'(prio_src_p);
      end else begin
         for (int k = 0; k < num_src_p; k++) begin
            w_scan = int'(r_rr_ptr) + k;
            if (w_scan >= num_src_p) begin
               w_scan = w_scan - num_src_p;
            end
            if (!w_pick_v && (w_scan != prio_src_p) && !w_fifo_empty[w_scan]) begin
               w_pick_v   = 1'b1;
               w_pick_src = grant_width_lp'(w_scan);
            end
         end
      end
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state <= e_idle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         e_idle: begin
            if (w_pick_v) begin
               w_state_next = e_send;
            end
         end
         e_send: begin
            if (io.byte_ready_and_i && w_last_byte) begin
`ifdef BP_FPGA_HOST_NBF_TX_CHECKSUM_EN
               w_state_next = e_csum;
`else
               w_state_next = e_idle;
`endif
            end
         end
`ifdef BP_FPGA_HOST_NBF_TX_CHECKSUM_EN
         e_csum: begin
            if (io.byte_ready_and_i) begin
               w_state_next = e_idle;
            end
         end
`endif
         default: w_state_next = e_idle;
      endcase
   end

   // Outputs: byte stream, grant and the FIFO-dequeue/load strobe
   always_comb begin
      io.byte_v_o    = 1'b0;
      io.byte_o      = r_shift[7:0];
      io.grant_src_o = (num_src_p > 1) ? r_grant : '0;
      w_load         = 1'b0;
      case (r_state)
         e_idle: w_load = w_pick_v;
         e_send: io.byte_v_o = 1'b1;
`ifdef BP_FPGA_HOST_NBF_TX_CHECKSUM_EN
         e_csum: begin
            io.byte_v_o = 1'b1;
            io.byte_o   = r_csum;
         end
`endif
         default: io.byte_v_o = 1'b0;
      endcase
      if (reset_i) begin
         io.byte_v_o    = 1'b0;
         io.grant_src_o = '0;
         w_load         = 1'b0;
      end
   end

   // Serializer datapath: load on grant, shift one byte per handshake
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_shift    <= '0;
         r_byte_idx <= '0;
         r_grant    <= '0;
         r_rr_ptr   <= '0;
`ifdef BP_FPGA_HOST_NBF_TX_CHECKSUM_EN
         r_csum     <= '0;
`endif
      end else if (w_load) begin
         r_shift    <= w_fifo_head[w_pick_src];
         r_byte_idx <= '0;
         r_grant    <= w_pick_src;
`ifdef BP_FPGA_HOST_NBF_TX_CHECKSUM_EN
         r_csum     <= '0;
`endif
         if (w_pick_src != grant_width_lp'(prio_src_p)) begin
            r_rr_ptr <= (w_pick_src == grant_width_lp'(num_src_p - 1)) ? '0
                        : w_pick_src + grant_width_lp'(1);
         end
      end else if (w_send_hs) begin
         r_shift    <= r_shift >> 8;
         r_byte_idx <= r_byte_idx + idx_width_lp'(1);
`ifdef BP_FPGA_HOST_NBF_TX_CHECKSUM_EN
         r_csum     <= r_csum ^ r_shift[7:0];
`endif
      end
   end
endmodule

// File: tb/tb_bp_fpga_host_nbf_tx_arb.sv
// Self-checking bench for bp_fpga_host_nbf_tx_arb (4 sources, priority 0).
// A queue-based packet model predicts every output each cycle; directed
// scenarios add hand-computed literal expectations.
`timescale 1ns/1ps
module tb_bp_fpga_host_nbf_tx_arb;
   localparam int N     = 4;
   localparam int AW    = 40;
   localparam int DW    = 64;
   localparam int W     = 8 + AW + DW;
   localparam int NB    = W / 8;
   localparam int DEPTH = 4;
`ifdef BP_FPGA_HOST_NBF_TX_CHECKSUM_EN
   localparam int WIRE = NB + 1;
`else
   localparam int WIRE = NB;
`endif

   typedef struct packed {
      bit [DW-1:0] data;
      bit [AW-1:0] addr;
      bit [7:0]    op;
   } pkt_t;

   typedef struct {
      string       name;
      logic [63:0] act;
      logic [63:0] exp;
   } lit_t;

   typedef struct {
      bit [7:0] b;
      int       g;
      int       c;
   } obs_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N*W-1:0] tb_nbf = '0;
   logic [N-1:0]   tb_v = '0;
   logic           tb_bready = 1'b1;

   always #5 clk = ~clk;

   bp_fpga_host_nbf_tx_arb_if #(.num_src_p(N), .nbf_addr_width_p(AW), .nbf_data_width_p(DW)) ifc ();

   assign ifc.nbf_i            = tb_nbf;
   assign ifc.nbf_v_i          = tb_v;
   assign ifc.byte_ready_and_i = tb_bready;

   bp_fpga_host_nbf_tx_arb #(
      .num_src_p(N), .nbf_addr_width_p(AW), .nbf_data_width_p(DW),
      .fifo_els_p(DEPTH), .prio_src_p(0)
   ) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .io      (ifc.slave)
   );

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   lit_t lq[$];
   obs_t obs[$];

   // Model state
   pkt_t mq [N][$];
   bit   m_sending = 1'b0;
   int   m_idx = 0;
   int   m_src = 0;
   pkt_t m_pkt = '0;
   int   m_rr = 0;

   bit [7:0] exp1 [NB] = '{8'h80, 8'h00, 8'h10, 8'h10, 8'h00, 8'h00, 8'h41,
                           8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
   int       exp_rr [6] = '{1, 2, 3, 1, 2, 3};

   // Byte i on the wire: opcode, addr bytes LSB first, data bytes LSB first, then checksum
   function automatic bit [7:0] wire_byte(pkt_t p, int i);
      bit [7:0] x;
      if (i == 0) return p.op;
      if (i <= AW / 8) return 8'(p.addr >> (8 * (i - 1)));
      if (i < NB) return 8'(p.data >> (8 * (i - 1 - AW / 8)));
      x = 8'h00;
      for (int j = 0; j < NB; j++) x = x ^ wire_byte(p, j);
      return x;
   endfunction

   function automatic pkt_t mk(int s, int n);
      pkt_t p;
      p.op   = 8'(8'h80 + s);
      p.addr = 40'(64'h0000_1234_5000 + 64'(s) * 64'h10_0000 + 64'(n) * 64'h18);
      p.data = {32'(s * 16 + n), 32'hA5C3_0000 + 32'(n * 7)};
      return p;
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic lit(string nm, logic [63:0] act, logic [63:0] exp);
      lq.push_back('{nm, act, exp});
   endtask

   // Packet-level model: advances at each clock edge from the bench's own inputs
   initial begin : model
      bit [N-1:0] acc;
      int         pick;
      forever begin
         @(posedge clk);
         for (int s = 0; s < N; s++) acc[s] = !rst && tb_v[s] && (mq[s].size() < DEPTH);
         if (rst) begin
            for (int s = 0; s < N; s++) mq[s].delete();
            m_sending = 1'b0;
            m_idx     = 0;
            m_rr      = 0;
         end else begin
            if (m_sending) begin
               if (tb_bready) begin
                  m_idx++;
                  if (m_idx == WIRE) m_sending = 1'b0;
               end
            end else begin
               pick = -1;
               if (mq[0].size() > 0) pick = 0;
               else begin
                  for (int k = 0; k < N; k++) begin
                     if (pick < 0 && ((m_rr + k) % N) != 0 && mq[(m_rr + k) % N].size() > 0)
                        pick = (m_rr + k) % N;
                  end
                  if (pick > 0) m_rr = (pick + 1) % N;
               end
               if (pick >= 0) begin
                  m_pkt     = mq[pick].pop_front();
                  m_src     = pick;
                  m_idx     = 0;
                  m_sending = 1'b1;
               end
            end
            for (int s = 0; s < N; s++)
               if (acc[s]) mq[s].push_back(pkt_t'(tb_nbf[s*W +: W]));
         end
      end
   end

   // Compare process: checks DUT outputs against the model every cycle
   initial begin : compare
      lit_t e;
      bit   exp_busy;
      forever begin
         @(negedge clk);
         cyc++;
         while (lq.size() > 0) begin
            e = lq.pop_front();
            chk(e.name, e.act, e.exp);
         end
         if (rst) begin
            chk("rst_byte_v", 64'(ifc.byte_v_o), 64'd0);
            chk("rst_busy", 64'(ifc.busy_o), 64'd0);
            chk("rst_ready", 64'(ifc.nbf_ready_and_o), 64'd0);
            chk("rst_grant", 64'(ifc.grant_src_o), 64'd0);
         end else begin
            chk("byte_v", 64'(ifc.byte_v_o), 64'(m_sending));
            if (m_sending) begin
               chk("byte", 64'(ifc.byte_o), 64'(wire_byte(m_pkt, m_idx)));
               chk("grant", 64'(ifc.grant_src_o), 64'(m_src));
            end
            exp_busy = m_sending;
            for (int s = 0; s < N; s++) begin
               chk("ready", 64'(ifc.nbf_ready_and_o[s]), 64'(mq[s].size() < DEPTH));
               if (mq[s].size() > 0) exp_busy = 1'b1;
            end
            chk("busy", 64'(ifc.busy_o), 64'(exp_busy));
         end
         if (ifc.byte_v_o === 1'b1 && tb_bready)
            obs.push_back('{ifc.byte_o, int'(ifc.grant_src_o), cyc});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pkt(int s, pkt_t p);
      tb_nbf[s*W +: W] = p;
   endtask

   task automatic push_one(int s, pkt_t p);
      bit ok;
      ok = 1'b0;
      set_pkt(s, p);
      tb_v[s] = 1'b1;
      for (int k = 0; k < 300 && !ok; k++) begin
         @(negedge clk);
         #1;
         ok = ifc.nbf_ready_and_o[s];
         step();
      end
      tb_v[s] = 1'b0;
      if (!ok) lit("push_timeout", 64'd0, 64'd1);
   endtask

   function automatic bit model_idle();
      bit idle;
      idle = !m_sending;
      for (int s = 0; s < N; s++) if (mq[s].size() > 0) idle = 1'b0;
      return idle;
   endfunction

   task automatic wait_idle(int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         if (model_idle()) break;
         step();
      end
      if (k == budget) lit("idle_timeout", 64'd0, 64'd1);
   endtask

   initial begin : stim
      int base;
      int acc_cyc;
      int pushed;
      int n;
      bit ok;

      // Reset
      rst = 1'b1;
      repeat (3) step();
      lit("rst_busy_lit", 64'(ifc.busy_o), 64'd0);
      rst = 1'b0;
      step();

      // Single packet from source 1
      base = obs.size();
      set_pkt(1, '{data: 64'h41, addr: 40'h00_0010_1000, op: 8'h80});
      tb_v[1] = 1'b1;
      @(negedge clk);
      #1;
      acc_cyc = cyc;
      ok = ifc.nbf_ready_and_o[1];
      step();
      tb_v[1] = 1'b0;
      lit("t1_ready", 64'(ok), 64'd1);
      wait_idle(100);
      lit("t1_count", 64'(obs.size() - base), 64'(WIRE));
      if (obs.size() >= base + WIRE) begin
         for (int i = 0; i < NB; i++) lit("t1_byte", 64'(obs[base+i].b), 64'(exp1[i]));
         lit("t1_latency", 64'(obs[base].c - acc_cyc), 64'd2);
         lit("t1_grant", 64'(obs[base].g), 64'd1);
`ifdef BP_FPGA_HOST_NBF_TX_CHECKSUM_EN
         lit("t1_csum", 64'(obs[base+NB].b), 64'hC1);
`endif
      end

      // Priority contention: sources 0 and 1 in the same cycle
      base = obs.size();
      set_pkt(0, mk(0, 0));
      set_pkt(1, mk(1, 0));
      tb_v = 4'b0011;
      step();
      tb_v = '0;
      wait_idle(200);
      lit("prio_count", 64'(obs.size() - base), 64'(2 * WIRE));
      if (obs.size() >= base + 2 * WIRE) begin
         lit("prio_first", 64'(obs[base].g), 64'd0);
         lit("prio_first_last", 64'(obs[base+WIRE-1].g), 64'd0);
         lit("prio_second", 64'(obs[base+WIRE].g), 64'd1);
         lit("prio_bubble", 64'(obs[base+WIRE].c - obs[base+WIRE-1].c), 64'd2);
      end

      // Round-robin over sources 1..3, two packets each, from a fresh pointer
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      step();
      base = obs.size();
      for (int r = 0; r < 2; r++) begin
         for (int s = 1; s < N; s++) set_pkt(s, mk(s, r + 1));
         tb_v = 4'b1110;
         step();
      end
      tb_v = '0;
      wait_idle(400);
      lit("rr_count", 64'(obs.size() - base), 64'(6 * WIRE));
      if (obs.size() >= base + 6 * WIRE) begin
         for (int p = 0; p < 6; p++) lit("rr_grant", 64'(obs[base+p*WIRE].g), 64'(exp_rr[p]));
      end

      // Backpressure with source 1 overfilling its FIFO
      tb_bready = 1'b0;
      base = obs.size();
      pushed = 0;
      for (int c = 0; c < 100; c++) begin
         if (pushed < 6) set_pkt(1, mk(1, 10 + pushed));
         tb_v[1] = (pushed < 6);
         @(negedge clk);
         #1;
         ok = ifc.nbf_ready_and_o[1];
         step();
         if (ok && tb_v[1]) pushed++;
      end
      tb_v = '0;
      lit("bp_accepted", 64'(pushed), 64'd5);
      lit("bp_no_bytes", 64'(obs.size() - base), 64'd0);
      tb_bready = 1'b1;
      while (pushed < 6) begin
         push_one(1, mk(1, 10 + pushed));
         pushed++;
      end
      wait_idle(500);
      lit("bp_count", 64'(obs.size() - base), 64'(6 * WIRE));

      // Reset in the middle of a packet with three more queued
      base = obs.size();
      for (int i = 0; i < 4; i++) push_one(2, mk(2, 20 + i));
      for (n = 0; n < 100 && obs.size() < base + 6; n++) begin
         @(negedge clk);
         #1;
      end
      if (n == 100) lit("rst_mid_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      #1;
      lit("rst_mid_byte_v", 64'(ifc.byte_v_o), 64'd0);
      lit("rst_mid_busy", 64'(ifc.busy_o), 64'd0);
      step();
      rst = 1'b0;
      n = obs.size();
      repeat (40) step();
      lit("rst_no_stale", 64'(obs.size() - n), 64'd0);
      lit("rst_idle_busy", 64'(ifc.busy_o), 64'd0);

      repeat (3) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
